// File: rtl/gmii_checker_pkg.sv
// rtl/gmii_checker_pkg.sv - shared types and constants for the GMII receive frame checker
package gmii_checker_pkg;

  typedef enum logic [2:0] {
    FS_GOOD     = 3'd0,
    FS_BAD_FCS  = 3'd1,
    FS_RUNT     = 3'd2,
    FS_OVERSIZE = 3'd3,
    FS_ERROR    = 3'd4
  } frame_status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } state_e;

  localparam int          NUM_CLASSES   = 5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/crc32_byte_update.sv
// rtl/crc32_byte_update.sv - combinational reflected CRC-32 update by one byte, LSB first
module crc32_byte_update
  import gmii_checker_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = {1'b0, c[31:1]} ^ (CRC_POLY & {32{c[0] ^ data_in[i]}});
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_frame_checker.sv
// rtl/gmii_rx_frame_checker.sv - passive GMII receive frame classifier with 64-bit counters and atomic snapshot
module gmii_rx_frame_checker
  import gmii_checker_pkg::*;
#(
  parameter int unsigned MAX_FRAME = 1518,
  parameter int unsigned MIN_FRAME = 64
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic        enable,
  input  logic        clear,
  input  logic        snapshot,
  output logic        frame_done,
  output logic [2:0]  frame_status,
  output logic [15:0] frame_len,
  output logic [63:0] snap_good,
  output logic [63:0] snap_bad_fcs,
  output logic [63:0] snap_runt,
  output logic [63:0] snap_oversize,
  output logic [63:0] snap_error,
  output logic [63:0] snap_good_bytes
);

  state_e        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [31:0]   crc_q, crc_d, crc_next;
  logic          err_q, err_d;
  logic          done_q, done_d;
  frame_status_e status_q, status_d;
  logic [15:0]   flen_q, flen_d;
  logic          classify;
  frame_status_e class_sel, data_class;

  logic [NUM_CLASSES-1:0][63:0] cnt_q, cnt_d, snap_cnt_q, snap_cnt_d;
  logic [63:0] gb_q, gb_d, snap_gb_q, snap_gb_d;

  crc32_byte_update u_crc (
    .crc_in  (crc_q),
    .data_in (gmii_rxd),
    .crc_out (crc_next)
  );

  always_comb begin
    if (err_q) begin
      data_class = FS_ERROR;
    end else if (len_q < 16'(MIN_FRAME)) begin
      data_class = FS_RUNT;
    end else if (len_q > 16'(MAX_FRAME)) begin
      data_class = FS_OVERSIZE;
    end else if (crc_q != CRC_RESIDUE) begin
      data_class = FS_BAD_FCS;
    end else begin
      data_class = FS_GOOD;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    crc_d     = crc_q;
    err_d     = err_q;
    classify  = 1'b0;
    class_sel = FS_ERROR;

    unique case (state_q)
      ST_IDLE: begin
        if (enable && gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            state_d = ST_PREAMBLE;
            len_d   = '0;
            err_d   = 1'b0;
          end else if (gmii_rxd == SFD_BYTE) begin
            state_d = ST_DATA;
            len_d   = '0;
            crc_d   = CRC_INIT;
            err_d   = 1'b0;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
        end else if (gmii_rx_er || (gmii_rxd != PREAMBLE_BYTE && gmii_rxd != SFD_BYTE)) begin
          state_d = ST_DROP;
          err_d   = 1'b1;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_d = ST_DATA;
          len_d   = '0;
          crc_d   = CRC_INIT;
        end
      end

      ST_DATA: begin
        if (gmii_rx_dv) begin
          len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          crc_d = crc_next;
          if (gmii_rx_er) begin
            err_d = 1'b1;
          end
        end else begin
          classify  = 1'b1;
          class_sel = data_class;
          state_d   = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (!gmii_rx_dv) begin
          classify  = 1'b1;
          class_sel = FS_ERROR;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done_d   = classify;
    status_d = classify ? class_sel : status_q;
    flen_d   = classify ? len_q : flen_q;
  end

  // Clear overrides a same-cycle update; snapshot always sees the pre-edge live values.
  always_comb begin
    cnt_d = cnt_q;
    gb_d  = gb_q;
    if (classify) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        if (3'(i) == class_sel) begin
          cnt_d[i] = cnt_q[i] + 64'd1;
        end
      end
      if (class_sel == FS_GOOD) begin
        gb_d = gb_q + {48'd0, len_q};
      end
    end
    if (clear) begin
      cnt_d = '0;
      gb_d  = '0;
    end
    snap_cnt_d = snapshot ? cnt_q : snap_cnt_q;
    snap_gb_d  = snapshot ? gb_q : snap_gb_q;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      crc_q      <= CRC_INIT;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= FS_GOOD;
      flen_q     <= '0;
      cnt_q      <= '0;
      gb_q       <= '0;
      snap_cnt_q <= '0;
      snap_gb_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      crc_q      <= crc_d;
      err_q      <= err_d;
      done_q     <= done_d;
      status_q   <= status_d;
      flen_q     <= flen_d;
      cnt_q      <= cnt_d;
      gb_q       <= gb_d;
      snap_cnt_q <= snap_cnt_d;
      snap_gb_q  <= snap_gb_d;
    end
  end

  assign frame_done      = done_q;
  assign frame_status    = status_q;
  assign frame_len       = flen_q;
  assign snap_good       = snap_cnt_q[FS_GOOD];
  assign snap_bad_fcs    = snap_cnt_q[FS_BAD_FCS];
  assign snap_runt       = snap_cnt_q[FS_RUNT];
  assign snap_oversize   = snap_cnt_q[FS_OVERSIZE];
  assign snap_error      = snap_cnt_q[FS_ERROR];
  assign snap_good_bytes = snap_gb_q;

endmodule

// File: tb/tb_gmii_rx_frame_checker.sv
// tb/tb_gmii_rx_frame_checker.sv - scoreboard bench for gmii_rx_frame_checker
module tb_gmii_rx_frame_checker;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        snapshot = 1'b0;
  logic        frame_done;
  logic [2:0]  frame_status;
  logic [15:0] frame_len;
  logic [63:0] snap_good, snap_bad_fcs, snap_runt, snap_oversize, snap_error, snap_good_bytes;

  gmii_rx_frame_checker dut (
    .aclk            (aclk),
    .reset           (reset),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .enable          (enable),
    .clear           (clear),
    .snapshot        (snapshot),
    .frame_done      (frame_done),
    .frame_status    (frame_status),
    .frame_len       (frame_len),
    .snap_good       (snap_good),
    .snap_bad_fcs    (snap_bad_fcs),
    .snap_runt       (snap_runt),
    .snap_oversize   (snap_oversize),
    .snap_error      (snap_error),
    .snap_good_bytes (snap_good_bytes)
  );

  always #4 aclk = ~aclk;

  typedef struct {
    int status;
    int len;
  } exp_t;

  exp_t              exp_q[$];
  int                n_cmp = 0;
  int                n_fail = 0;
  longint unsigned   cnt_m[5];
  longint unsigned   gb_m;
  longint unsigned   snap_m[5];
  longint unsigned   snap_gb_m;
  logic [7:0]        frm[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n, input bit ramp);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < n - 4; i++) frm.push_back(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
    f = fcs_of(n - 4);
    for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
  endtask

  function automatic int model_status(input bit err);
    int n;
    n = frm.size();
    if (err) return 4;
    if (n < 64) return 2;
    if (n > 1518) return 3;
    if (fcs_of(n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]}) return 1;
    return 0;
  endfunction

  task automatic cyc(input logic dv, input logic [7:0] d, input logic er);
    @(posedge aclk);
    #1;
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    gmii_rx_er = er;
    clear      = 1'b0;
    snapshot   = 1'b0;
  endtask

  task automatic send(input int npre, input int er_idx, input bit bad_pre, input int gap,
                      input bit clr, input bit snp, input bit en_drop);
    exp_t e;
    bit   counted;
    counted = enable;
    if (bad_pre) begin
      repeat (3) cyc(1'b1, 8'h55, 1'b0);
      cyc(1'b1, 8'h5A, 1'b0);
      repeat (4) cyc(1'b1, 8'h55, 1'b0);
      cyc(1'b1, 8'hD5, 1'b0);
    end else begin
      repeat (npre) cyc(1'b1, 8'h55, 1'b0);
      cyc(1'b1, 8'hD5, 1'b0);
    end
    if (en_drop) enable = 1'b0;
    for (int i = 0; i < frm.size(); i++) cyc(1'b1, frm[i], i == er_idx);
    cyc(1'b0, 8'h00, 1'b0);
    clear    = clr;
    snapshot = snp;
    if (counted) begin
      e.status = bad_pre ? 4 : model_status(er_idx >= 0);
      e.len    = bad_pre ? -1 : frm.size();
      exp_q.push_back(e);
      if (snp) begin
        snap_m    = cnt_m;
        snap_gb_m = gb_m;
      end
      if (clr) begin
        foreach (cnt_m[i]) cnt_m[i] = 0;
        gb_m = 0;
      end else begin
        cnt_m[e.status]++;
        if (e.status == 0) gb_m += longint'(e.len);
      end
    end
    if (en_drop) enable = 1'b1;
    repeat (gap - 1) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic cmp_snap(input string tag);
    @(negedge aclk);
    chk({tag, ".snap_good"},       snap_good,       snap_m[0]);
    chk({tag, ".snap_bad_fcs"},    snap_bad_fcs,    snap_m[1]);
    chk({tag, ".snap_runt"},       snap_runt,       snap_m[2]);
    chk({tag, ".snap_oversize"},   snap_oversize,   snap_m[3]);
    chk({tag, ".snap_error"},      snap_error,      snap_m[4]);
    chk({tag, ".snap_good_bytes"}, snap_good_bytes, snap_gb_m);
  endtask

  task automatic snap_check(input string tag);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    snapshot  = 1'b1;
    snap_m    = cnt_m;
    snap_gb_m = gb_m;
    cyc(1'b0, 8'h00, 1'b0);
    cmp_snap(tag);
  endtask

  task automatic do_clear();
    cyc(1'b0, 8'h00, 1'b0);
    clear = 1'b1;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    gb_m = 0;
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (frame_done === 1'b1) begin
        chk("frame_done_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frame_status", 64'(frame_status), 64'(e.status));
          if (e.len >= 0) chk("frame_len", 64'(frame_len), 64'(e.len));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    foreach (cnt_m[i]) cnt_m[i] = 0;
    foreach (snap_m[i]) snap_m[i] = 0;
    gb_m = 0;
    snap_gb_m = 0;
    repeat (4) @(posedge aclk);
    #1;
    reset = 1'b0;
    @(negedge aclk);
    chk("reset.frame_done",   64'(frame_done),   64'd0);
    chk("reset.frame_status", 64'(frame_status), 64'd0);
    chk("reset.frame_len",    64'(frame_len),    64'd0);
    cmp_snap("reset");

    build_frame(64, 1'b1);
    send(7, -1, 1'b0, 12, 1'b0, 1'b0, 1'b0);
    snap_check("good64");
    chk("good64.snap_good_bytes_abs", snap_good_bytes, 64'd64);

    build_frame(64, 1'b1);
    frm[10] ^= 8'h01;
    send(7, -1, 1'b0, 12, 1'b0, 1'b0, 1'b0);
    build_frame(56, 1'b0);
    send(7, -1, 1'b0, 12, 1'b0, 1'b0, 1'b0);
    build_frame(1519, 1'b0);
    send(7, -1, 1'b0, 12, 1'b0, 1'b0, 1'b0);
    build_frame(1518, 1'b0);
    send(7, -1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    build_frame(64, 1'b1);
    send(7, 20, 1'b0, 12, 1'b0, 1'b0, 1'b0);
    send(7, -1, 1'b1, 12, 1'b0, 1'b0, 1'b0);
    build_frame(64, 1'b0);
    send(0, -1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    snap_check("directed");

    do_clear();
    for (int k = 0; k < 100; k++) begin
      build_frame(64, 1'b1);
      send(7, -1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    end
    snap_check("b2b100");
    chk("b2b100.good_abs",  snap_good,       64'd100);
    chk("b2b100.bytes_abs", snap_good_bytes, 64'd6400);

    build_frame(64, 1'b1);
    send(7, -1, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    build_frame(80, 1'b0);
    send(7, -1, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    build_frame(70, 1'b0);
    send(7, -1, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    cmp_snap("snap_with_update");
    build_frame(66, 1'b0);
    send(5, -1, 1'b0, 4, 1'b1, 1'b1, 1'b0);
    cmp_snap("snap_with_clear");
    snap_check("after_clear");

    enable = 1'b0;
    build_frame(64, 1'b0);
    send(7, -1, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    build_frame(64, 1'b0);
    send(7, -1, 1'b0, 4, 1'b0, 1'b0, 1'b1);
    snap_check("enable");

    build_frame(64, 1'b1);
    repeat (7) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b1, frm[i], 1'b0);
    @(posedge aclk);
    #1;
    reset = 1'b1;
    gmii_rx_dv = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    foreach (snap_m[i]) snap_m[i] = 0;
    gb_m = 0;
    snap_gb_m = 0;
    cmp_snap("midreset");
    build_frame(64, 1'b1);
    send(7, -1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    snap_check("post_reset");

    for (int k = 0; k < 40; k++) begin
      int n;
      int er;
      bit bp;
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1510, 1525)) : int'($urandom_range(30, 120));
      build_frame(n, 1'b0);
      if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, n - 1)] ^= 8'(1 << $urandom_range(0, 7));
      er = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      bp = ($urandom_range(0, 11) == 0);
      send(int'($urandom_range(0, 7)), er, bp, int'($urandom_range(1, 12)), 1'b0, 1'b0, 1'b0);
    end
    snap_check("random");

    repeat (5) cyc(1'b0, 8'h00, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gmii_rx_frame_checker.md
# gmii_rx_frame_checker

Passive GMII receive-side frame checker placed between the SFP port's PCS/PMA GMII receive output and the gmii_mux, in parallel with the MAC. It consumes the looped-back traffic produced by traffic_generator_gmii and classifies each frame as good, bad FCS, runt, oversize or error. It keeps 64-bit per-class counters plus a good-byte counter, with an atomic snapshot so software can read 64-bit values as two 32-bit halves without tearing.

## Interface
- MAX_FRAME, 1518: largest legal frame length in bytes, counted from after the SFD through the FCS inclusive.
- MIN_FRAME, 64: smallest legal frame length in bytes, same counting.
- aclk  in  1  GMII receive clock, 125 MHz; the only clock.
- reset  in  1  synchronous, active-high.
- gmii_rxd  in  8  receive data.
- gmii_rx_dv  in  1  data valid.
- gmii_rx_er  in  1  receive error.
- enable  in  1  when 0, no new frame starts; a frame already in progress completes normally.
- clear  in  1  single-cycle pulse; zeroes all live counters.
- snapshot  in  1  single-cycle pulse; copies all live counters into the snap_* registers.
- frame_done  out  1  single-cycle pulse when a frame is classified.
- frame_status  out  3  class of the last frame: 0 good, 1 bad_fcs, 2 runt, 3 oversize, 4 error. Valid with frame_done and held afterwards.
- frame_len  out  16  byte length of the last frame, saturating at 0xFFFF.
- snap_good, snap_bad_fcs, snap_runt, snap_oversize, snap_error, snap_good_bytes  out  64 each  snapshot copies of the live counters.

## Operation
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE -> PREAMBLE when enable=1 and rx_dv=1 and rxd=0x55. IDLE -> DATA when enable=1 and rx_dv=1 and rxd=0xD5, which covers a GMII that has lost its preamble.
- PREAMBLE:
  - rxd=0x55: stay.
  - rxd=0xD5: go to DATA; clear the length counter; load the CRC register with 0xFFFFFFFF.
  - any other byte, or rx_er=1: go to DROP and set the error flag.
  - rx_dv falls: return to IDLE silently; nothing is counted.
- DATA: each byte with rx_dv=1 increments the length counter (saturating) and updates the CRC.
  - CRC: reflected polynomial 0xEDB88320, LSB first, one byte per cycle.
  - rx_er=1 on any cycle sets the sticky error flag.
- Classification happens on the first cycle with rx_dv=0 in DATA. Priority: error flag -> error; len<MIN_FRAME -> runt; len>MAX_FRAME -> oversize; CRC register ≠ 0xDEBB20E3 -> bad_fcs; otherwise good.
- The matching counter increments by 1. For a good frame only, good_bytes increments by len.
- After classification, return to IDLE.
- DROP: wait for rx_dv=0, then classify the frame as error and go to IDLE.
- rx_er while rx_dv=0 (carrier extension or false carrier) is ignored.
- All counters are 64-bit and wrap modulo 2^64.

## Timing
- Reset: FSM goes to IDLE. All live counters, snap_* registers, frame_len and frame_status are 0. frame_done is 0.
- frame_done, frame_status and frame_len register one cycle after the first rx_dv=0 cycle of a frame. The live counter update lands on the same edge.
- Live counters are visible through snap_* one cycle after a snapshot pulse. snap_* hold their value until the next snapshot or reset.
- Snapshot in the same cycle as a counter update: the snapshot captures the pre-update values.
- Clear in the same cycle as a counter update: clear wins and the frame is not counted. frame_done still pulses. Clear does not touch snap_*.
- Clear and snapshot together: the snapshot captures the pre-clear values.
- The back-to-back minimum is one rx_dv=0 cycle between frames. There must be no lost frame at the 12-cycle IFG or at a 1-cycle gap.
- Reset mid-frame: the frame is abandoned, with no frame_done and no count.
- enable falling mid-frame has no effect on that frame.

## Structure
- Shared package gmii_checker_pkg holds:
  - the frame_status enum;
  - the state enum;
  - CRC_INIT=0xFFFFFFFF;
  - CRC_POLY=0xEDB88320;
  - CRC_RESIDUE=0xDEBB20E3;
  - preamble and SFD byte constants 0x55 and 0xD5.
- One sub-module, crc32_byte_update: a purely combinational next-CRC function taking the current CRC and one data byte.
- The top level contains the FSM, the length counter, the classifier and the counter bank.

## Test plan
- 7×0x55, 0xD5, 60 payload bytes (0x00..0x3B), correct 4-byte FCS -> frame_done, status 0, len 64. After a snapshot: snap_good=1, snap_good_bytes=64.
- Same frame with payload byte 10 XOR 0x01 -> status 1, snap_bad_fcs=1, snap_good_bytes unchanged.
- 56-byte frame with a valid FCS -> status 2, len 56. A 1519-byte frame -> status 3, len 1519.
- rx_er asserted on byte 20 of a 64-byte frame -> status 4. A preamble byte of 0x5A -> DROP, then status 4 on rx_dv fall.
- 100 good 64-byte frames back to back with a 1-cycle gap -> snap_good=100, snap_good_bytes=6400.
- Clear coinciding with the classification cycle, plus snapshot coinciding with a later update -> that frame is not counted, and the snapshot shows pre-update values. Reset at DATA byte 30 -> no frame_done; the next frame is counted correctly.
